// File: rtl/lsu_access_ctrl.sv
// LSU access controller: decodes an LSU request into an SRAM access, an
// output-buffer write or an unmapped no-op, and answers with a one-cycle done.
module lsu_access_ctrl #(
  parameter int unsigned SRAM_WAIT = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_lsu_req,
  input  logic        i_lsu_wren,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_lsu_wdata,
  output logic        o_lsu_ready,
  output logic        o_lsu_done,
  output logic [31:0] o_lsu_rdata,
  output logic        o_sram_ce,
  output logic        o_sram_we,
  output logic [10:0] o_sram_addr,
  output logic [31:0] o_sram_wdata,
  input  logic [31:0] i_sram_rdata,
  output logic        o_out_wren,
  output logic [7:0]  o_out_addr,
  output logic [31:0] o_out_wdata
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LADDR_W = 13;
  localparam int unsigned SADDR_W = 11;
  localparam int unsigned OADDR_W = 8;

  typedef enum logic [1:0] {IDLE, SRAM, OUT, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 wren_q, wren_d;

  logic                 ready_d, done_d, ce_d, we_d, out_wren_d;
  logic [SADDR_W-1:0]   sram_addr_d;
  logic [DATA_W-1:0]    sram_wdata_d, out_wdata_d, rdata_d;
  logic [OADDR_W-1:0]   out_addr_d;

  logic                 sram_hit, out_hit, last_wait;
  logic                 unused_addr_hi;

  // Upper address half never participates in decode.
  assign unused_addr_hi = ^i_lsu_addr[31:16];

  assign sram_hit  = (i_lsu_addr[15:13] == 3'b001);
  assign out_hit   = i_lsu_wren && (i_lsu_addr[15:12] == 4'b0111) &&
                     (i_lsu_addr[11:8] == 4'b0000);
  assign last_wait = (cnt_q == CNT_W'(SRAM_WAIT - 1));

  // Next-state, latched request and next registered output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wren_d  = wren_q;
    rdata_d = o_lsu_rdata;

    case (state_q)
      IDLE: begin
        if (i_lsu_req) begin
          addr_d  = i_lsu_addr[LADDR_W-1:0];
          wdata_d = i_lsu_wdata;
          wren_d  = i_lsu_wren;
          cnt_d   = '0;
          if (sram_hit) begin
            state_d = SRAM;
          end else if (out_hit) begin
            state_d = OUT;
          end else begin
            state_d = DONE;
            rdata_d = '0;
          end
        end
      end
      SRAM: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (last_wait) begin
          state_d = DONE;
          rdata_d = wren_q ? '0 : i_sram_rdata;
        end
      end
      OUT: begin
        state_d = DONE;
        rdata_d = '0;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    ready_d      = (state_d == IDLE);
    done_d       = (state_d == DONE);
    ce_d         = (state_d == SRAM);
    we_d         = ce_d && wren_d;
    sram_addr_d  = ce_d ? addr_d[12:2] : '0;
    sram_wdata_d = ce_d ? wdata_d : '0;
    out_wren_d   = (state_d == OUT);
    out_addr_d   = out_wren_d ? addr_d[7:0] : '0;
    out_wdata_d  = out_wren_d ? wdata_d : '0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wren_q       <= 1'b0;
      o_lsu_ready  <= 1'b1;
      o_lsu_done   <= 1'b0;
      o_lsu_rdata  <= '0;
      o_sram_ce    <= 1'b0;
      o_sram_we    <= 1'b0;
      o_sram_addr  <= '0;
      o_sram_wdata <= '0;
      o_out_wren   <= 1'b0;
      o_out_addr   <= '0;
      o_out_wdata  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wren_q       <= wren_d;
      o_lsu_ready  <= ready_d;
      o_lsu_done   <= done_d;
      o_lsu_rdata  <= rdata_d;
      o_sram_ce    <= ce_d;
      o_sram_we    <= we_d;
      o_sram_addr  <= sram_addr_d;
      o_sram_wdata <= sram_wdata_d;
      o_out_wren   <= out_wren_d;
      o_out_addr   <= out_addr_d;
      o_out_wdata  <= out_wdata_d;
    end
  end

endmodule
